// File: rtl/octal_bin_enc.sv
// Registered 8-to-3 (octal-to-binary) encoder.
//
// Converts an 8-bit one-hot input into the 3-bit binary index of the set bit.
// It also flags whether any bit was set (valid) and whether more than one was set (err).
// When several bits are set, PRIORITY_MSB picks the winner:
//   1 -> the highest set bit, 0 -> the lowest set bit.
// All outputs are registered, so there is one cycle of latency and no combinational path
// from the input to any output.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   in_i     - one-hot octal input; bit k set means code k
//   out_o    - registered binary index of the winning set bit
//   valid_o  - registered; at least one bit was set in the sampled input
//   err_o    - registered; more than one bit was set in the sampled input

module octal_bin_enc #(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_i,
    output logic [2:0] out_o,
    output logic       valid_o,
    output logic       err_o
);

    logic [2:0] out_d, out_q;
    logic       valid_d, valid_q;
    logic       err_d, err_q;

    always_comb begin
        out_d = 3'b000;
        if (PRIORITY_MSB) begin
            // Ascending scan: the last set bit seen is the highest one.
            for (int i = 0; i < 8; i++) begin
                if (in_i[i]) out_d = 3'(i);
            end
        end else begin
            // Descending scan: the last set bit seen is the lowest one.
            for (int i = 7; i >= 0; i--) begin
                if (in_i[i]) out_d = 3'(i);
            end
        end
        valid_d = |in_i;
        // Clearing the lowest set bit leaves something behind only when the input is multi-hot.
        err_d   = |(in_i & (in_i - 8'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 3'b000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_octal_bin_enc.sv
module tb_octal_bin_enc;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_v;
    logic [2:0] out_m, out_l;
    logic       valid_m, valid_l, err_m, err_l;

    int checks   = 0;
    int failures = 0;

    octal_bin_enc #(.PRIORITY_MSB(1'b1)) u_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (in_v),
        .out_o   (out_m),
        .valid_o (valid_m),
        .err_o   (err_m)
    );

    octal_bin_enc #(.PRIORITY_MSB(1'b0)) u_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (in_v),
        .out_o   (out_l),
        .valid_o (valid_l),
        .err_o   (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: packs {out, valid, err} from the input's set-bit positions.
    function automatic logic [4:0] model(input logic [7:0] v, input bit msb);
        int n;
        int hi;
        int lo;
        n  = 0;
        hi = -1;
        lo = 8;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                n++;
                if (k > hi) hi = k;
                if (k < lo) lo = k;
            end
        end
        if (n == 0) return 5'b000_0_0;
        return {(msb ? 3'(hi) : 3'(lo)), 1'b1, (n > 1)};
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed={out,valid,err}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [7:0] v);
        chk({tag, "/msb"}, {out_m, valid_m, err_m}, model(v, 1'b1));
        chk({tag, "/lsb"}, {out_l, valid_l, err_l}, model(v, 1'b0));
    endtask

    // Drive on the falling edge, then check #1 after the rising edge that samples it.
    task automatic step(input string tag, input logic [7:0] v);
        @(negedge clk);
        in_v = v;
        @(posedge clk);
        #1;
        chk_both(tag, v);
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        in_v  = 8'hFF;

        // Held in reset with every input bit set.
        repeat (3) @(posedge clk);
        #1;
        chk({"reset_hold", "/msb"}, {out_m, valid_m, err_m}, 5'b0);
        chk({"reset_hold", "/lsb"}, {out_l, valid_l, err_l}, 5'b0);

        @(negedge clk);
        rst_n = 1'b1;
        step("ff_after_release", 8'hFF);

        // Asynchronous clear between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk({"async_clear", "/msb"}, {out_m, valid_m, err_m}, 5'b0);
        chk({"async_clear", "/lsb"}, {out_l, valid_l, err_l}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Walking one.
        for (int k = 0; k < 8; k++) step($sformatf("walk%0d", k), 8'(1 << k));

        // Zero input, then code 0.
        step("zero", 8'h00);
        step("code0_after_zero", 8'h01);

        // Multi-hot cases.
        step("multi_81", 8'h81);
        step("multi_14", 8'h14);
        step("multi_ff", 8'hFF);

        // Back-to-back random one-hot values.
        for (int i = 0; i < 40; i++) begin
            r = 8'(1 << $urandom_range(7, 0));
            step($sformatf("rand_onehot%0d", i), r);
        end

        // Mid-stream reset pulse: clears asynchronously, tracking resumes after release.
        @(negedge clk);
        in_v = 8'h24;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({"mid_reset", "/msb"}, {out_m, valid_m, err_m}, 5'b0);
        chk({"mid_reset", "/lsb"}, {out_l, valid_l, err_l}, 5'b0);
        @(posedge clk);
        #1;
        chk({"mid_reset_edge", "/msb"}, {out_m, valid_m, err_m}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("resume", 8'h40);

        // Arbitrary random bytes: zero, one-hot and multi-hot all appear.
        for (int i = 0; i < 60; i++) begin
            r = 8'($urandom);
            if (i % 7 == 0) r = 8'h00;
            step($sformatf("rand_byte%0d", i), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
